// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the adder result stream.
// Default adder width used by downstream stages.
package sum_accumulator_pkg;
  localparam int ADDER_DATA_W = 16;
endpackage

// File: rtl/sum_block_counter.sv
// Per-block beat and carry counters.
// Flags the completing beat; clear zeroes both counts.
module sum_block_counter #(
  parameter int BLOCK_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             accept,
  input  logic             carry,
  output logic             last,
  output logic [CNT_W-1:0] carries_next
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] carries;

  assign last = (cnt == CNT_W'(BLOCK_LEN - 1));
  assign carries_next = carries + {{(CNT_W-1){1'b0}}, carry};

  // Count beats and carries; wrap to zero on the completing beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      carries <= '0;
    end else if (clear) begin
      cnt     <= '0;
      carries <= '0;
    end else if (accept) begin
      if (last) begin
        cnt     <= '0;
        carries <= '0;
      end else begin
        cnt     <= cnt + 1'b1;
        carries <= carries_next;
      end
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates blocks of adder results into a wide total.
// One-deep record register decouples block output from input.
import sum_accumulator_pkg::*;

module sum_accumulator #(
  parameter int DATA_W    = ADDER_DATA_W,
  parameter int ACC_W     = 24,
  parameter int BLOCK_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_c_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_carries,
  output logic              out_ovf
);

  logic [ACC_W-1:0] acc;
  logic             ovf_sticky;
  logic             last;
  logic [CNT_W-1:0] carries_next;
  logic             accept;
  logic             complete;
  logic [ACC_W:0]   addend;
  logic [ACC_W:0]   sum_next;
  logic             ovf_next;

  // Only the completing beat has to wait for a free record slot
  assign in_ready = !(out_valid && last);
  assign accept   = in_valid && in_ready;
  assign complete = accept && last && !clear;

  assign addend   = {{(ACC_W-DATA_W){1'b0}}, in_c_out, in_sum};
  assign sum_next = {1'b0, acc} + addend;
  assign ovf_next = ovf_sticky | sum_next[ACC_W];

  sum_block_counter #(
    .BLOCK_LEN (BLOCK_LEN),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .accept       (accept),
    .carry        (in_c_out),
    .last         (last),
    .carries_next (carries_next)
  );

  // Running total and wrap flag for the open block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else if (accept) begin
      if (last) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
      end else begin
        acc        <= sum_next[ACC_W-1:0];
        ovf_sticky <= ovf_next;
      end
    end
  end

  // Record register: load on completion, drop on retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_acc     <= '0;
      out_carries <= '0;
      out_ovf     <= 1'b0;
    end else if (complete) begin
      out_valid   <= 1'b1;
      out_acc     <= sum_next[ACC_W-1:0];
      out_carries <= carries_next;
      out_ovf     <= ovf_next;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule
